// File: rtl/pdpm_axis_hdr_upsizer.sv
// pdpm_axis_hdr_upsizer
// Drops a fixed number of link-header beats from each received packet and packs
// the remaining payload from an IN_W-bit stream into OUT_W-bit words with tkeep
// and tlast. Within an output word, the earliest beat sits in the lowest lane.
// It also counts forwarded packets and runt packets.
//
// Handshake: a beat moves on either side only in a cycle where tvalid && tready.
// The output word is held stable until it transfers. Input is accepted only when
// the output register is empty or is draining in the same cycle.
module pdpm_axis_hdr_upsizer #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 64,
    parameter int HDR_BEATS = 14,
    parameter int CNT_W     = 32
) (
    input  logic               axis_aclk,
    input  logic               axis_aresetn,
    input  logic [IN_W-1:0]    s_axis_tdata,
    input  logic               s_axis_tvalid,
    input  logic               s_axis_tlast,
    output logic               s_axis_tready,
    output logic [OUT_W-1:0]   m_axis_tdata,
    output logic [OUT_W/8-1:0] m_axis_tkeep,
    output logic               m_axis_tvalid,
    output logic               m_axis_tlast,
    input  logic               m_axis_tready,
    output logic [CNT_W-1:0]   pkt_cnt,
    output logic [CNT_W-1:0]   runt_cnt
);

    localparam int R        = OUT_W / IN_W;
    localparam int KB       = IN_W / 8;
    localparam int KW       = OUT_W / 8;
    localparam int IDX_W    = $clog2(R);
    localparam int HC_W     = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
    localparam int HDR_LAST = (HDR_BEATS > 0) ? HDR_BEATS - 1 : 0;

    typedef enum logic {
        ST_HDR,
        ST_PAY
    } state_e;

    state_e           state_q, state_d;
    logic [HC_W-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [KW-1:0]    acc_keep_q, acc_keep_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [KW-1:0]    m_keep_q, m_keep_d;
    logic             m_valid_q, m_valid_d;
    logic             m_last_q, m_last_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;

    logic             s_fire;
    logic             word_done;
    logic [OUT_W-1:0] acc_wr;
    logic [KW-1:0]    keep_wr;

    // Ready whenever the output slot is free or being emptied this cycle; held low in reset.
    assign s_axis_tready = axis_aresetn & (~m_valid_q | m_axis_tready);
    assign s_fire        = s_axis_tvalid & s_axis_tready;

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign runt_cnt      = runt_cnt_q;

    // Next-state: header skipping, lane packing, output register load/drain, statistics.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_valid_d  = m_valid_q;
        m_last_d   = m_last_q;
        pkt_cnt_d  = pkt_cnt_q;
        runt_cnt_d = runt_cnt_q;

        // Accumulator as it would look with the current beat merged into lane idx.
        acc_wr                       = acc_q;
        keep_wr                      = acc_keep_q;
        acc_wr[idx_q*IN_W +: IN_W]   = s_axis_tdata;
        keep_wr[idx_q*KB +: KB]      = '1;
        word_done                    = (idx_q == IDX_W'(R - 1)) | s_axis_tlast;

        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end

        if (s_fire) begin
            if (state_q == ST_HDR) begin
                if (s_axis_tlast) begin
                    // Packet ended inside the header: nothing to forward.
                    runt_cnt_d = runt_cnt_q + 1'b1;
                    hdr_cnt_d  = '0;
                end else if (hdr_cnt_q == HC_W'(HDR_LAST)) begin
                    state_d   = ST_PAY;
                    hdr_cnt_d = '0;
                end else begin
                    hdr_cnt_d = hdr_cnt_q + 1'b1;
                end
            end else begin
                if (word_done) begin
                    m_data_d   = acc_wr;
                    m_keep_d   = keep_wr;
                    m_valid_d  = 1'b1;
                    m_last_d   = s_axis_tlast;
                    acc_d      = '0;
                    acc_keep_d = '0;
                    idx_d      = '0;
                    if (s_axis_tlast) begin
                        pkt_cnt_d = pkt_cnt_q + 1'b1;
                        if (HDR_BEATS > 0) begin
                            state_d = ST_HDR;
                        end
                    end
                end else begin
                    acc_d      = acc_wr;
                    acc_keep_d = keep_wr;
                    idx_d      = idx_q + 1'b1;
                end
            end
        end
    end

    // State and output registers; reset drops any partial word and header progress.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q    <= (HDR_BEATS == 0) ? ST_PAY : ST_HDR;
            hdr_cnt_q  <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            pkt_cnt_q  <= '0;
            runt_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            pkt_cnt_q  <= pkt_cnt_d;
            runt_cnt_q <= runt_cnt_d;
        end
    end

endmodule

// File: doc/pdpm_axis_hdr_upsizer.md
Name: pdpm_axis_hdr_upsizer

Overview:
Parametrised successor to the fixed 8-bit network-to-memory AXI-Stream path. It strips a fixed-length link header from each received packet and packs the remaining payload from an IN_W-bit network stream into an OUT_W-bit memory-side stream, with tkeep and tlast. It sits between the Ethernet MAC receive FIFO and the memory subsystem's slave AXI-Stream port. It also keeps packet and runt statistics.

Parameters:
IN_W, 8, input tdata width in bits; a multiple of 8.
OUT_W, 64, output tdata width in bits; OUT_W = R*IN_W with R >= 2 an integer.
HDR_BEATS, 14, number of leading input beats dropped per packet; 0 is legal and disables stripping.
CNT_W, 32, width of the statistic counters.

Ports:
axis_aclk  in  1  the single clock.
axis_aresetn  in  1  reset, asynchronous active-low.
s_axis_tdata  in  IN_W  network payload.
s_axis_tvalid  in  1  input beat valid.
s_axis_tlast  in  1  last beat of the packet.
s_axis_tready  out  1  input accept.
m_axis_tdata  out  OUT_W  packed word; the earliest beat is in the lowest lane.
m_axis_tkeep  out  OUT_W/8  byte-valid mask.
m_axis_tvalid  out  1  output word valid.
m_axis_tlast  out  1  last word of the packet.
m_axis_tready  in  1  downstream accept.
pkt_cnt  out  CNT_W  count of packets forwarded with at least one payload beat.
runt_cnt  out  CNT_W  count of packets that ended at or before the last header beat.

Behaviour:
- Reset (async assert, sync release):
  - s_axis_tready, m_axis_tvalid, m_axis_tlast = 0.
  - m_axis_tdata, m_axis_tkeep = 0.
  - Both counters = 0.
  - State = HDR (PAY when HDR_BEATS = 0); header counter = 0; lane index = 0; accumulator cleared.
- Beat transfer: an input beat transfers when s_axis_tvalid && s_axis_tready. An output word transfers when m_axis_tvalid && m_axis_tready.
- s_axis_tready = !m_axis_tvalid || m_axis_tready, forced to 0 during reset.
  - Input stalls whenever a held output word is not being drained, even if the beat would not complete a word.
- State HDR:
  - Accepted beats are discarded and the header counter increments.
  - On the beat with header counter = HDR_BEATS-1 and tlast = 0: go to PAY and clear the header counter.
  - Any accepted beat with tlast = 1 in HDR (runt): increment runt_cnt, clear the header counter, stay in HDR, emit nothing.
- State PAY:
  - An accepted beat writes lane[idx] of the accumulator, sets the IN_W/8 keep bits for that lane, and increments idx.
  - A word completes when idx = R-1 or tlast = 1. In the same clock, accumulator+keep load the output register, m_axis_tvalid <= 1, and m_axis_tlast <= tlast. Lanes not written are 0 with keep 0.
  - The accumulator and idx are then cleared.
  - On completion with tlast = 1: increment pkt_cnt, then go to HDR (stay in PAY when HDR_BEATS = 0).
- Latency: m_axis_tvalid rises one cycle after the completing beat is accepted.
- Throughput: one input beat per cycle is sustained when m_axis_tready = 1.
- m_axis_tvalid drops after a transfer unless a new word loads in that same cycle (simultaneous drain + load keeps tvalid = 1 with new data).
- AXI-S rules:
  - Output data, keep and last stay stable while tvalid && !tready.
  - tvalid is never retracted before a transfer.
- Counters wrap modulo 2^CNT_W.
- Reset mid-packet: the partial word and header progress are lost, the output is deasserted immediately (async), and the next beat after release is treated as the first beat of a new packet.

Test Plan:
- IN_W=8, OUT_W=32, HDR_BEATS=2, m_tready=1; send bytes 0x00..0x09 as one packet -> two words: 0x05040302 with keep 0xF, then 0x09080706 with keep 0xF and tlast. pkt_cnt=1.
- Same configuration, bytes 0x00..0x0A -> words as above, plus 0x0000000A with keep 0x1 and tlast on the third word only. pkt_cnt=1.
- Runt packets 0x00 (tlast on beat 0) and 0x00,0x01 (tlast on beat 1) -> no output beats and runt_cnt=2. A following 6-byte packet 0x10..0x15 yields 0x15141312 with keep 0xF and tlast.
- Backpressure: m_tready=0 for 5 cycles once the first word is valid -> tdata/tkeep stay stable and s_tready=0. After release, all words arrive in order with no loss or duplication.
- HDR_BEATS=0, OUT_W=64: back-to-back packets of 8 and 3 bytes with tvalid held high -> words keep 0xFF (tlast), then keep 0x07 (tlast). pkt_cnt=2, with no idle input cycle.
- Assert axis_aresetn=0 after 3 payload beats -> m_tvalid=0 immediately. After release, a fresh 10-byte packet reproduces scenario 1 exactly.
